// File: rtl/unidade_busca_pkg.sv
// pkg_cpu: opcodes, fetch-stage state type and shared helpers for the CPU
package pkg_cpu;

   localparam int LARGURA_OPCODE = 5;

   localparam logic [LARGURA_OPCODE-1:0] OP_NOP  = 5'b00000;
   localparam logic [LARGURA_OPCODE-1:0] OP_HLT  = 5'b00001;
   localparam logic [LARGURA_OPCODE-1:0] OP_IN   = 5'b00010;
   localparam logic [LARGURA_OPCODE-1:0] OP_OUT  = 5'b00011;
   localparam logic [LARGURA_OPCODE-1:0] OP_ADD  = 5'b00100;
   localparam logic [LARGURA_OPCODE-1:0] OP_SUB  = 5'b00101;
   localparam logic [LARGURA_OPCODE-1:0] OP_AND  = 5'b00110;
   localparam logic [LARGURA_OPCODE-1:0] OP_OR   = 5'b00111;
   localparam logic [LARGURA_OPCODE-1:0] OP_XOR  = 5'b01000;
   localparam logic [LARGURA_OPCODE-1:0] OP_NOT  = 5'b01001;
   localparam logic [LARGURA_OPCODE-1:0] OP_SLL  = 5'b01010;
   localparam logic [LARGURA_OPCODE-1:0] OP_SRL  = 5'b01011;
   localparam logic [LARGURA_OPCODE-1:0] OP_ADDI = 5'b01100;
   localparam logic [LARGURA_OPCODE-1:0] OP_SUBI = 5'b01101;
   localparam logic [LARGURA_OPCODE-1:0] OP_LI   = 5'b01110;
   localparam logic [LARGURA_OPCODE-1:0] OP_MOV  = 5'b01111;
   localparam logic [LARGURA_OPCODE-1:0] OP_LW   = 5'b10000;
   localparam logic [LARGURA_OPCODE-1:0] OP_SW   = 5'b10001;
   localparam logic [LARGURA_OPCODE-1:0] OP_JMP  = 5'b10010;
   localparam logic [LARGURA_OPCODE-1:0] OP_BEQ  = 5'b10011;
   localparam logic [LARGURA_OPCODE-1:0] OP_BNE  = 5'b10100;
   localparam logic [LARGURA_OPCODE-1:0] OP_BLT  = 5'b10101;
   localparam logic [LARGURA_OPCODE-1:0] OP_BGT  = 5'b10110;
   localparam logic [LARGURA_OPCODE-1:0] OP_SLT  = 5'b10111;

   typedef enum logic [1:0] {
      EXECUTA,
      ESPERA,
      LIBERA,
      PARADO
   } estado_busca_t;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] incrementa_sat(input logic [31:0] valor);
      return (&valor) ? valor : valor + 32'd1;
   endfunction

endpackage

// File: rtl/unidade_busca_sincroniza_borda.sv
// sincroniza_borda: 2-flop synchronizer for an async level plus rising-edge pulse
module sincroniza_borda (
   input  logic clock,
   input  logic reset_n,
   input  logic entrada,
   output logic borda
);

   logic [2:0] sinc_q, sinc_d;

   // Shift the raw level through two metastability flops and one history flop.
   always_comb begin
      sinc_d = {sinc_q[1:0], entrada};
   end

   // Chain register; cleared asynchronously so no stale edge survives a reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) sinc_q <= '0;
      else          sinc_q <= sinc_d;
   end

   assign borda = sinc_q[1] & ~sinc_q[2];

endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: PC register and fetch sequencing with IN stall and halt
module unidade_busca
   import pkg_cpu::*;
#(
   parameter int LARGURA_PC = 10
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [31:0]           instrucao,
   input  logic                  jump,
   input  logic [31:0]           jumpE,
   input  logic                  halt,
   input  logic                  confirma,
   output logic [LARGURA_PC-1:0] pc,
   output logic [4:0]            opcode,
   output logic                  avanca,
   output logic                  esperando_in,
   output logic                  parado,
   output logic [31:0]           contagem_instr
);

   estado_busca_t         estado_q, estado_d;
   logic [LARGURA_PC-1:0] pc_q, pc_d;
   logic [31:0]           contagem_q, contagem_d;
   logic                  retira;
   logic                  borda_confirma;
   logic                  bits_unused;

   sincroniza_borda u_sincroniza (
      .clock   (clock),
      .reset_n (reset_n),
      .entrada (confirma),
      .borda   (borda_confirma)
   );

   assign opcode      = instrucao[31:27];
   assign bits_unused = ^{jumpE[31:LARGURA_PC], instrucao[26:0]};

   // Next-state, next-PC and retire decision; halt outranks IN, IN outranks jump.
   always_comb begin
      estado_d = estado_q;
      pc_d     = pc_q;
      retira   = 1'b0;
      unique case (estado_q)
         EXECUTA: begin
            if (halt) begin
               retira   = 1'b1;
               estado_d = PARADO;
            end else if (opcode == OP_IN) begin
               estado_d = ESPERA;
            end else begin
               retira = 1'b1;
               pc_d   = jump ? jumpE[LARGURA_PC-1:0] : pc_q + LARGURA_PC'(1);
            end
         end
         ESPERA: begin
            estado_d = borda_confirma ? LIBERA : ESPERA;
         end
         LIBERA: begin
            retira   = 1'b1;
            pc_d     = pc_q + LARGURA_PC'(1);
            estado_d = EXECUTA;
         end
         default: begin
            estado_d = PARADO;
         end
      endcase
   end

   // Retire strobe is forced low while reset is held, even though state already reads EXECUTA.
   always_comb begin
      avanca     = retira & reset_n;
      contagem_d = avanca ? incrementa_sat(contagem_q) : contagem_q;
   end

   // Architectural state of the fetch stage.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q   <= EXECUTA;
         pc_q       <= '0;
         contagem_q <= '0;
      end else begin
         estado_q   <= estado_d;
         pc_q       <= pc_d;
         contagem_q <= contagem_d;
      end
   end

   assign pc             = pc_q;
   assign contagem_instr = contagem_q;
   assign esperando_in   = (estado_q == ESPERA);
   assign parado         = (estado_q == PARADO);

endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: directed scoreboard bench for the fetch stage (10-bit and 4-bit PC)
module tb_unidade_busca;

   localparam logic [31:0] NOP = 32'h0000_0000;
   localparam logic [31:0] INS = 32'h1000_0000;
   localparam logic [31:0] HLT = 32'h0800_0000;

   typedef struct {
      string      nome;
      bit         sel;
      logic [9:0] pc;
      logic [4:0] op;
      logic       av;
      logic       esp;
      logic       par;
      logic [31:0] cnt;
   } esperado_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] instrucao = '0;
   logic        jump = 1'b0;
   logic [31:0] jumpE = '0;
   logic        halt = 1'b0;
   logic        confirma = 1'b0;

   logic [9:0]  pc;
   logic [4:0]  opcode;
   logic        avanca, esperando_in, parado;
   logic [31:0] contagem_instr;

   logic [3:0]  pc4;
   logic [4:0]  opcode4;
   logic        avanca4, esperando_in4, parado4;
   logic [31:0] contagem_instr4;

   esperado_t   fila[$];
   esperado_t   e;
   int          checks = 0;
   int          errors = 0;
   logic [49:0] atual, requerido;

   unidade_busca #(.LARGURA_PC(10)) dut (
      .clock(clock), .reset_n(reset_n), .instrucao(instrucao), .jump(jump), .jumpE(jumpE),
      .halt(halt), .confirma(confirma), .pc(pc), .opcode(opcode), .avanca(avanca),
      .esperando_in(esperando_in), .parado(parado), .contagem_instr(contagem_instr)
   );

   unidade_busca #(.LARGURA_PC(4)) dut4 (
      .clock(clock), .reset_n(reset_n), .instrucao(instrucao), .jump(jump), .jumpE(jumpE),
      .halt(halt), .confirma(confirma), .pc(pc4), .opcode(opcode4), .avanca(avanca4),
      .esperando_in(esperando_in4), .parado(parado4), .contagem_instr(contagem_instr4)
   );

   always #5 clock = ~clock;

   // Monitor: every sampled cycle with a pending expectation is compared mid-cycle.
   always @(negedge clock) begin
      if (fila.size() > 0) begin
         e = fila.pop_front();
         atual = e.sel ? {6'b0, pc4, opcode4, avanca4, esperando_in4, parado4, contagem_instr4}
                       : {pc, opcode, avanca, esperando_in, parado, contagem_instr};
         requerido = {e.pc, e.op, e.av, e.esp, e.par, e.cnt};
         checks++;
         if (atual !== requerido) begin
            errors++;
            $display("FAIL %s dut%0d got pc=%0h op=%0h av=%0b esp=%0b par=%0b cnt=%0d expected pc=%0h op=%0h av=%0b esp=%0b par=%0b cnt=%0d",
                     e.nome, e.sel ? 4 : 10, atual[49:40], atual[39:35], atual[34], atual[33], atual[32], atual[31:0],
                     e.pc, e.op, e.av, e.esp, e.par, e.cnt);
         end
      end
   end

   task automatic cyc(input string n, input logic [31:0] ins, input logic j, input logic [31:0] je,
                      input logic h, input logic cf, input bit s, input logic [9:0] ep,
                      input logic ea, input logic ee, input logic epa, input logic [31:0] ec);
      instrucao = ins;
      jump      = j;
      jumpE     = je;
      halt      = h;
      confirma  = cf;
      fila.push_back('{n, s, ep, ins[31:27], ea, ee, epa, ec});
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      @(posedge clock);
      #1;
      cyc("reset", NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("reset", NOP, 1, 32'h3, 0, 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) cyc("seq", NOP, 0, 0, 0, 0, 0, 10'(i), 1, 0, 0, 32'(i));
      cyc("seq5_jmp4", NOP, 1, 32'h4, 0, 0, 0, 5, 1, 0, 0, 5);
      cyc("jmp_123", NOP, 1, 32'h123, 0, 0, 0, 4, 1, 0, 0, 6);
      cyc("at_123", NOP, 1, 32'h7, 0, 0, 0, 10'h123, 1, 0, 0, 7);
      cyc("in_fetch", INS, 0, 0, 0, 0, 0, 7, 0, 0, 0, 8);
      for (int i = 0; i < 50; i++) cyc("in_wait", INS, 1, 32'h3FF, 1, 0, 0, 7, 0, 1, 0, 8);
      for (int i = 0; i < 3; i++) cyc("in_press", INS, 0, 0, 0, 1, 0, 7, 0, 1, 0, 8);
      cyc("in_libera", INS, 1, 32'h200, 0, 1, 0, 7, 1, 0, 0, 8);
      cyc("in2_fetch", INS, 0, 0, 0, 1, 0, 8, 0, 0, 0, 9);
      for (int i = 0; i < 10; i++) cyc("in2_held", INS, 0, 0, 0, 1, 0, 8, 0, 1, 0, 9);
      for (int i = 0; i < 5; i++) cyc("in2_release", INS, 0, 0, 0, 0, 0, 8, 0, 1, 0, 9);
      for (int i = 0; i < 3; i++) cyc("in2_press", INS, 0, 0, 0, 1, 0, 8, 0, 1, 0, 9);
      cyc("in2_libera", INS, 0, 0, 0, 1, 0, 8, 1, 0, 0, 9);
      cyc("after_in2", NOP, 0, 0, 0, 0, 0, 9, 1, 0, 0, 10);
      for (int i = 0; i < 4; i++) cyc("exec_press", NOP, i == 3, 32'h9, 0, 1, 0, 10'(10 + i), 1, 0, 0, 32'(11 + i));
      cyc("in3_fetch", INS, 0, 0, 0, 1, 0, 9, 0, 0, 0, 15);
      for (int i = 0; i < 10; i++) cyc("in3_held", INS, 0, 0, 0, 1, 0, 9, 0, 1, 0, 15);
      reset_n = 1'b0;
      cyc("rst_async", INS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("rst_hold", NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;
      cyc("restart", NOP, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc("halt_jmp", HLT, 1, 32'h55, 1, 0, 0, 1, 1, 0, 0, 1);
      for (int i = 0; i < 100; i++)
         cyc("parado", INS, logic'(i % 2), 32'h77, logic'((i / 2) % 2), logic'((i / 4) % 2), 0, 1, 0, 0, 1, 2);
      reset_n = 1'b0;
      cyc("rst4", NOP, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) cyc("step4", NOP, 0, 0, 0, 0, 1, 10'(i), 1, 0, 0, 32'(i));
      cyc("wrap4", NOP, 1, 32'hFFFF_FFF3, 0, 0, 1, 0, 1, 0, 0, 16);
      cyc("jmp4", NOP, 0, 0, 0, 0, 1, 3, 1, 0, 0, 17);
      @(negedge clock);
      #1;
      checks++;
      if (fila.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected 0", fila.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/unidade_busca.md
# unidade_busca

Program-counter and fetch-sequencing stage that sits directly upstream of the control unit. It owns the PC register, drives the instruction-memory address, and forwards the fetched opcode field to the control unit. It applies the control unit's `jump`/`jumpE`/`halt` decisions at the clock edge. It also stalls the processor on an `IN` instruction until the operator presses a confirm button, and gates architectural writes through `avanca`.

## Interface

Parameters:
- `LARGURA_PC`, default 10: PC/instruction-address width; instruction memory depth is 2^LARGURA_PC.

Ports:
- `clock`  in  1  system clock; all state is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instrucao`  in  32  instruction word from instruction memory, combinational read of `pc`; opcode is `instrucao[31:27]`.
- `jump`  in  1  from control unit: take branch this cycle.
- `jumpE`  in  32  from control unit: branch target; only bits [LARGURA_PC-1:0] are used.
- `halt`  in  1  from control unit: stop execution.
- `confirma`  in  1  raw asynchronous push-button level, active-high.
- `pc`  out  LARGURA_PC  current instruction address.
- `opcode`  out  5  `instrucao[31:27]`, passed combinationally to the control unit.
- `avanca`  out  1  the current instruction retires this cycle; the top level ANDs it into `escreveR`, `escreveM` and `escreverOut`.
- `esperando_in`  out  1  high while in ESPERA.
- `parado`  out  1  high while in PARADO.
- `contagem_instr`  out  32  retired-instruction counter, saturating at 32'hFFFF_FFFF.

## Operation

- States are EXECUTA, ESPERA, LIBERA and PARADO. Reset enters EXECUTA.
- Reset values: `pc`=0, `avanca`=0 during reset, `esperando_in`=0, `parado`=0, `contagem_instr`=0, synchronizer flops 0.
- **EXECUTA**, decided in this priority order:
  1. `halt`=1: `avanca`=1. Next state is PARADO. `pc` holds. `halt` has priority over `jump`.
  2. Else, opcode==OP_IN (5'b00010): `avanca`=0. Next state is ESPERA. `pc` holds.
  3. Else, `jump`=1: `avanca`=1. `pc` <= `jumpE[LARGURA_PC-1:0]`.
  4. Else: `avanca`=1. `pc` <= `pc`+1, modulo 2^LARGURA_PC, so the top address wraps to 0.
- **ESPERA**:
  - `avanca`=0 and `esperando_in`=1; `pc` holds.
  - A synchronized rising edge of `confirma` moves the block to LIBERA.
  - A held level does not retrigger.
- **LIBERA** (one cycle):
  - `avanca`=1, so the IN instruction writes its register this cycle.
  - `pc` <= `pc`+1, with wrap.
  - Next state is EXECUTA.
- **PARADO**: `avanca`=0 and `parado`=1. `pc` holds. The block leaves this state only on reset.
- **Retire counter**: `contagem_instr` increments on every cycle with `avanca`=1, and saturates at its maximum.
- **Confirm input**: `confirma` passes through a 2-flop synchronizer; a third flop provides edge detection. The edge pulse is computed every cycle but acted on only in ESPERA; edges arriving in any other state are discarded.
- **Unused inputs**: `jump`/`jumpE` are ignored outside EXECUTA, and `halt` is ignored outside EXECUTA.

## Timing

- `pc` updates one cycle after the decision cycle. A branch taken in cycle N presents the target address in cycle N+1.
- `avanca`, `opcode`, `esperando_in` and `parado` are combinational from state and inputs. `pc` and `contagem_instr` are registered.
- Confirm latency: a press held stable from cycle K is synchronized by K+2, produces its edge at K+2, shows LIBERA with `avanca`=1 at K+3, and the next instruction's `pc` at K+4.
- Reset asserted in any state forces all registers to their reset values immediately (asynchronously). After `reset_n` deasserts, the first rising edge resumes from EXECUTA with `pc`=0.
- An `IN` whose confirm edge arrived before the IN was fetched still waits for a new edge.

## Structure

- Shared package `pkg_cpu`:
  - opcode constants `OP_NOP`, `OP_HLT`, `OP_IN` and the remaining opcodes, shared with the control unit;
  - state enum `estado_busca_t` with EXECUTA, ESPERA, LIBERA and PARADO.
- One sub-module, `sincroniza_borda`: a 2-flop synchronizer plus rising-edge detector with the same async active-low reset. It is reused by the I/O blocks.

## Test plan

- **Sequential fetch:** reset, then a NOP stream for 5 cycles -> `pc` reads 0,1,2,3,4,5; `contagem_instr`=5; `avanca`=1 throughout.
- **Jump, and halt priority:**
  - `jump`=1 with `jumpE`=32'h0000_0123 at `pc`=4 -> next `pc`=10'h123.
  - `halt`=1 and `jump`=1 in the same cycle -> `pc` holds; `parado`=1 on the next cycle and stays 1 for 100 further cycles.
- **IN stall:**
  - OP_IN fetched at `pc`=7 -> `avanca`=0 and `esperando_in`=1, with `pc`=7 held for 50 cycles.
  - Press `confirma` -> exactly one `avanca`=1 cycle 3 cycles after the press, then `pc`=8.
- **Held button:**
  - `confirma` held high across two consecutive IN instructions -> the second IN waits until release and a new press.
  - A press during EXECUTA is ignored.
- **Wrap-around:** with LARGURA_PC=4, step from `pc`=15 with no jump -> `pc`=0. A `jumpE` of 32'hFFFF_FFF3 -> `pc`=3.
- **Reset mid-wait:** assert `reset_n`=0 while in ESPERA at `pc`=9 -> `pc`=0, `esperando_in`=0 and `contagem_instr`=0 immediately, without waiting for a clock edge. After release, fetch restarts at 0.
